// File: rtl/imem_loader_pkg.sv
// Shared types for the boot-time imem loader.
// Holds the FSM state encoding, word geometry and a byte-insert helper.
package imem_loader_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  // Little-endian lane insert: byte k lands in bits [8k+7:8k].
  function automatic logic [31:0] put_byte(
    input logic [31:0] w,
    input logic [1:0]  k,
    input logic [7:0]  b
  );
    logic [31:0] r;
    r = w;
    r[8*k +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Host byte stream (valid/ready) plus imem test/load write port.
// master: host/imem side; slave: the loader.
interface imem_loader_if;

  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic [31:0] test_addr;
  logic [31:0] test_data_in;
  logic        test_we;

  modport master (
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  test_addr,
    input  test_data_in,
    input  test_we
  );

  modport slave (
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output test_addr,
    output test_data_in,
    output test_we
  );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted bytes into a 32-bit little-endian word.
// Ports: clk, reset (async low), clear, accept, byte_data -> word, word_valid.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  cnt_q;
  logic [31:0] word_q;

  // word already contains the byte being accepted this cycle,
  // so the FSM can latch it on the same edge as the 4th byte.
  assign word = put_byte(word_q, cnt_q, byte_data);
  assign word_valid =
    accept && (cnt_q == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else if (clear) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else if (accept) begin
      cnt_q  <= cnt_q + 2'd1;
      word_q <= word;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: byte stream -> 32-bit imem words, holds core in reset until loaded.
// Ports: clk, reset (async low), start, bus (imem_loader_if.slave),
//        cpu_reset_n, busy, done, error. Option: IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int WORD_COUNT = 256,
  parameter int ADDR_W     = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  imem_loader_if.slave  bus,
  output logic          cpu_reset_n,
  output logic          busy,
  output logic          done,
  output logic          error
);

  state_t state_q, state_d;

  logic [ADDR_W-1:0] idx_q;
  logic [31:0]       addr_q;
  logic [31:0]       data_q;

  logic        ready;
  logic        accept;
  logic        clear;
  logic        load_word;
  logic        we;
  logic        last;
  logic        run;
  logic        busy_c;
  logic        done_c;
  logic        err_c;
  logic [31:0] word;
  logic        word_valid;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] sum_q;
`endif

  // Ready is a pure state decode so it never depends on byte_valid.
  assign ready =
    (state_q == S_RECV) || (state_q == S_CHECK);
  assign accept = bus.byte_valid && ready;
  assign last = idx_q == ADDR_W'(WORD_COUNT - 1);

  imem_loader_byte_packer u_byte_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .accept     (accept),
    .byte_data  (bus.byte_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    clear     = 1'b0;
    load_word = 1'b0;
    we        = 1'b0;
    run       = 1'b0;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    err_c     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          clear   = 1'b1;
          state_d = S_RECV;
        end
      end
      S_RECV: begin
        busy_c = 1'b1;
        if (word_valid) begin
          load_word = 1'b1;
          state_d   = S_WRITE;
        end
      end
      S_WRITE: begin
        busy_c = 1'b1;
        we     = 1'b1;
        if (last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_RECV;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        busy_c = 1'b1;
        if (word_valid) begin
          if (word == sum_q) state_d = S_DONE;
          else               state_d = S_ERROR;
        end
      end
      S_ERROR: begin
        err_c = 1'b1;
        if (start) begin
          clear   = 1'b1;
          state_d = S_RECV;
        end
      end
`endif
      S_DONE: begin
        run    = 1'b1;
        done_c = 1'b1;
        if (start) begin
          clear   = 1'b1;
          state_d = S_RECV;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Index saturates on the last word; only a new start rewinds it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            idx_q <= '0;
    else if (clear)        idx_q <= '0;
    else if (we && !last)  idx_q <= idx_q + 1'b1;
  end

  // Write port registers hold their value outside WRITE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q <= '0;
      data_q <= '0;
    end else if (load_word) begin
      addr_q <= 32'(idx_q);
      data_q <= word;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     sum_q <= '0;
    else if (clear) sum_q <= '0;
    else if (we)    sum_q <= sum_q + data_q;
  end
`endif

  assign bus.byte_ready   = ready;
  assign bus.test_addr    = addr_q;
  assign bus.test_data_in = data_q;
  assign bus.test_we      = we;

  assign cpu_reset_n = run;
  assign busy        = busy_c;
  assign done        = done_c;
  assign error       = err_c;

endmodule
